sha256_axil_driver: RTL and testbench
=====================================

SHA256_AXIL_DRIVER -- requirements
Module: sha256_axil_driver

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h44B0_0000, byte base address of the SHA-256 AXI4-Lite slave.
REQ-002 The block SHALL have parameter POLL_LIMIT, default 1024, maximum status reads per block (used only with REQ-030).
REQ-003 The block SHALL have port aclk, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-004 The block SHALL have port areset, input, 1, reset; synchronous, active-high.
REQ-005 The block SHALL have ports cmd_valid input 1, cmd_ready output 1, cmd_block input 512, cmd_init input 1, forming the block request handshake; cmd_init=1 means first block of a message.
REQ-006 The block SHALL have ports done output 1, error output 1, digest output 256, forming a one-cycle completion pulse with result.
REQ-007 The block SHALL have AXI4-Lite master write ports awaddr out 32, awprot out 3 (always 0), awvalid out 1, awready in 1, wdata out 32, wstrb out 4 (always 4'hF), wvalid out 1, wready in 1, bresp in 2, bvalid in 1, bready out 1.
REQ-008 The block SHALL have AXI4-Lite master read ports araddr out 32, arprot out 3 (always 0), arvalid out 1, arready in 1, rdata in 32, rresp in 2, rvalid in 1, rready out 1.

Function
REQ-009 Register map SHALL be: CTRL=BASE+4, STATUS=BASE+8 (bit1 digest_valid), BLOCK word i=BASE+20+4*i (i=0..15), DIGEST word j=BASE+84+4*j (j=0..7).
REQ-010 cmd_ready SHALL be 1 only in state IDLE; a block is accepted on cmd_valid&&cmd_ready and cmd_block/cmd_init are captured in that cycle.
REQ-011 States SHALL be IDLE, WADDR, WRESP, POLL_AR, POLL_R, DIG_AR, DIG_R, FINISH.
REQ-012 Write sequence SHALL be 18 writes in order: BLOCK word 0..15 with data cmd_block[511-32*i -: 32], then CTRL with 32'h5 (cmd_init=1) or 32'h6 (cmd_init=0), then CTRL with 32'h4.
REQ-013 In WADDR awvalid and wvalid SHALL assert together in the same cycle; each SHALL drop independently after its own handshake; state SHALL advance to WRESP only when both have completed, in any order or in the same cycle.
REQ-014 In WRESP bready SHALL be 1; on bvalid with bresp==2'b00 the write counter increments and state returns to WADDR or, after write 18, goes to POLL_AR.
REQ-015 awaddr/wdata/araddr SHALL be stable while the corresponding valid is high and unacknowledged.
REQ-016 POLL_AR SHALL issue a read of STATUS; POLL_R (rready=1) SHALL, on rvalid with OKAY, go to DIG_AR if rdata[1]==1, else back to POLL_AR.
REQ-017 DIG_AR/DIG_R SHALL read DIGEST words 0..7 in order, storing word j in digest[255-32*j -: 32], then enter FINISH.
REQ-018 FINISH SHALL pulse done=1, error=0 for exactly one cycle and return to IDLE; digest SHALL hold its value until the next completed block.
REQ-019 Any bresp or rresp != 2'b00 SHALL abort the sequence: next cycle done=1, error=1 for one cycle, state to IDLE, digest unchanged.
REQ-020 At most one AXI write and one AXI read SHALL be outstanding; reads and writes never overlap.
REQ-021 Minimum latency from accept to done SHALL be 18*2 + 2 + 8*2 + 1 = 55 cycles with zero-wait-state slave and one status poll.
REQ-022 cmd_valid while busy SHALL be ignored (not captured, no effect).

Reset
REQ-023 On areset=1 at a rising edge the state SHALL become IDLE, counters cleared, regardless of any in-flight transaction.
REQ-024 Reset values SHALL be: cmd_ready=1 after reset release, done=0, error=0, digest=0, awvalid=wvalid=arvalid=0, bready=rready=0, awaddr=wdata=araddr=0.
REQ-025 Reset mid-transaction SHALL drop all valids the same edge; late bvalid/rvalid after reset SHALL be ignored.

Configuration
REQ-030 With macro SHA256_AXIL_DRIVER_TIMEOUT_EN defined, a poll counter SHALL count STATUS reads per block; reaching POLL_LIMIT without digest_valid SHALL abort as in REQ-019 (done=1, error=1).
REQ-031 Without SHA256_AXIL_DRIVER_TIMEOUT_EN the block SHALL poll indefinitely and contain no poll counter.

Verification
REQ-040 "abc": cmd_block = 32'h61626380, 14 zero words, 32'h00000018, cmd_init=1 -> writes seen at BASE+20..BASE+80, CTRL 5 then 4, done=1 error=0, digest = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-041 Slave delays awready 3 cycles but wready immediate (and reverse) -> exactly one write per address, sequence and digest as in REQ-040.
REQ-042 Slave returns bresp=2'b10 on BLOCK word 5 -> done=1 error=1 one cycle after bvalid, no CTRL write issued, digest unchanged.
REQ-043 areset asserted for 1 cycle during DIG_R -> all valids 0 next cycle, cmd_ready=1 after release, done never pulses.
REQ-044 With SHA256_AXIL_DRIVER_TIMEOUT_EN, POLL_LIMIT=4, STATUS always 0 -> exactly 4 STATUS reads then done=1 error=1.
REQ-045 Second block with cmd_init=0 -> CTRL writes 6 then 4; cmd_valid asserted while busy -> ignored.

Source files
------------

// File: rtl/sha256_axil_driver.sv
// AXI4-Lite master that feeds one 512-bit block to a SHA-256 slave, polls STATUS and reads back the digest.
// Optional macro SHA256_AXIL_DRIVER_TIMEOUT_EN bounds the STATUS poll to POLL_LIMIT reads per block.
module sha256_axil_driver #(
    parameter logic [31:0] BASE_ADDR  = 32'h44B0_0000,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [511:0] cmd_block,
    input  logic         cmd_init,
    output logic         done,
    output logic         error,
    output logic [255:0] digest,
    output logic [31:0]  awaddr,
    output logic [2:0]   awprot,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wvalid,
    input  logic         wready,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready,
    output logic [31:0]  araddr,
    output logic [2:0]   arprot,
    output logic         arvalid,
    input  logic         arready,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rvalid,
    output logic         rready
);

    localparam logic [31:0] CTRL_OFS   = 32'd4;
    localparam logic [31:0] STATUS_OFS = 32'd8;
    localparam logic [31:0] BLOCK_OFS  = 32'd20;
    localparam logic [31:0] DIGEST_OFS = 32'd84;
    localparam logic [4:0]  LAST_WRITE = 5'd17;
    localparam logic [2:0]  LAST_READ  = 3'd7;

    typedef enum logic [2:0] {
        IDLE, WADDR, WRESP, POLL_AR, POLL_R, DIG_AR, DIG_R, FINISH
    } state_t;

    state_t         state, nxt_state;
    logic [4:0]     wr_cnt, nxt_wr_cnt;
    logic [2:0]     rd_cnt, nxt_rd_cnt;
    logic           aw_done, nxt_aw_done;
    logic           w_done, nxt_w_done;
    logic [511:0]   blk, nxt_blk;
    logic           init, nxt_init;
    logic [255:0]   dig_buf, nxt_dig_buf;
    logic           nxt_cmd_ready, nxt_done, nxt_error;
    logic [255:0]   nxt_digest;
    logic [31:0]    nxt_awaddr, nxt_wdata, nxt_araddr;
    logic           nxt_awvalid, nxt_wvalid, nxt_bready, nxt_arvalid, nxt_rready;
    logic           aw_hs, w_hs, b_hs, ar_hs, r_hs, abort;

`ifdef SHA256_AXIL_DRIVER_TIMEOUT_EN
    localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
    logic [PW-1:0] poll_cnt, nxt_poll_cnt;
`endif

    assign awprot = 3'b000;
    assign arprot = 3'b000;
    assign wstrb  = 4'hF;

    // Write k: BLOCK words 0..15, then CTRL start, then CTRL release.
    function automatic logic [31:0] wr_addr(input logic [4:0] k);
        if (k < 5'd16) return BASE_ADDR + BLOCK_OFS + (32'(k) << 2);
        return BASE_ADDR + CTRL_OFS;
    endfunction

    function automatic logic [31:0] wr_data(input logic [4:0] k, input logic [511:0] b,
                                            input logic ini);
        logic [31:0] r;
        r = (k == 5'd16) ? (ini ? 32'h5 : 32'h6) : 32'h4;
        for (int i = 0; i < 16; i++) begin
            if (k == 5'(i)) r = b[511-32*i -: 32];
        end
        return r;
    endfunction

    always_comb begin
        nxt_state     = state;
        nxt_wr_cnt    = wr_cnt;
        nxt_rd_cnt    = rd_cnt;
        nxt_aw_done   = aw_done;
        nxt_w_done    = w_done;
        nxt_blk       = blk;
        nxt_init      = init;
        nxt_dig_buf   = dig_buf;
        nxt_cmd_ready = cmd_ready;
        nxt_done      = 1'b0;
        nxt_error     = 1'b0;
        nxt_digest    = digest;
        nxt_awaddr    = awaddr;
        nxt_wdata     = wdata;
        nxt_araddr    = araddr;
        nxt_awvalid   = awvalid;
        nxt_wvalid    = wvalid;
        nxt_bready    = bready;
        nxt_arvalid   = arvalid;
        nxt_rready    = rready;
`ifdef SHA256_AXIL_DRIVER_TIMEOUT_EN
        nxt_poll_cnt  = poll_cnt;
`endif
        abort = 1'b0;
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        b_hs  = bvalid && bready;
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;

        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    nxt_blk       = cmd_block;
                    nxt_init      = cmd_init;
                    nxt_wr_cnt    = 5'd0;
                    nxt_awaddr    = wr_addr(5'd0);
                    nxt_wdata     = wr_data(5'd0, cmd_block, cmd_init);
                    nxt_awvalid   = 1'b1;
                    nxt_wvalid    = 1'b1;
                    nxt_aw_done   = 1'b0;
                    nxt_w_done    = 1'b0;
                    nxt_cmd_ready = 1'b0;
                    nxt_state     = WADDR;
                end
            end
            // Address and data channels complete independently; leave once both have.
            WADDR: begin
                if (aw_hs) begin
                    nxt_awvalid = 1'b0;
                    nxt_aw_done = 1'b1;
                end
                if (w_hs) begin
                    nxt_wvalid = 1'b0;
                    nxt_w_done = 1'b1;
                end
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    nxt_state  = WRESP;
                    nxt_bready = 1'b1;
                end
            end
            WRESP: begin
                if (b_hs) begin
                    nxt_bready = 1'b0;
                    if (bresp != 2'b00) begin
                        abort = 1'b1;
                    end else if (wr_cnt == LAST_WRITE) begin
                        nxt_state   = POLL_AR;
                        nxt_arvalid = 1'b1;
                        nxt_araddr  = BASE_ADDR + STATUS_OFS;
`ifdef SHA256_AXIL_DRIVER_TIMEOUT_EN
                        nxt_poll_cnt = '0;
`endif
                    end else begin
                        nxt_wr_cnt  = wr_cnt + 5'd1;
                        nxt_awaddr  = wr_addr(wr_cnt + 5'd1);
                        nxt_wdata   = wr_data(wr_cnt + 5'd1, blk, init);
                        nxt_awvalid = 1'b1;
                        nxt_wvalid  = 1'b1;
                        nxt_aw_done = 1'b0;
                        nxt_w_done  = 1'b0;
                        nxt_state   = WADDR;
                    end
                end
            end
            POLL_AR: begin
                if (ar_hs) begin
                    nxt_arvalid = 1'b0;
                    nxt_rready  = 1'b1;
                    nxt_state   = POLL_R;
                end
            end
            POLL_R: begin
                if (r_hs) begin
                    nxt_rready = 1'b0;
                    if (rresp != 2'b00) begin
                        abort = 1'b1;
                    end else if (rdata[1]) begin
                        nxt_rd_cnt  = 3'd0;
                        nxt_araddr  = BASE_ADDR + DIGEST_OFS;
                        nxt_arvalid = 1'b1;
                        nxt_state   = DIG_AR;
                    end else begin
`ifdef SHA256_AXIL_DRIVER_TIMEOUT_EN
                        if (32'(poll_cnt) + 32'd1 >= POLL_LIMIT) begin
                            abort = 1'b1;
                        end else begin
                            nxt_poll_cnt = poll_cnt + PW'(1);
                            nxt_arvalid  = 1'b1;
                            nxt_state    = POLL_AR;
                        end
`else
                        nxt_arvalid = 1'b1;
                        nxt_state   = POLL_AR;
`endif
                    end
                end
            end
            DIG_AR: begin
                if (ar_hs) begin
                    nxt_arvalid = 1'b0;
                    nxt_rready  = 1'b1;
                    nxt_state   = DIG_R;
                end
            end
            // Words land in a shadow buffer so an aborted read-back leaves digest intact.
            DIG_R: begin
                if (r_hs) begin
                    nxt_rready = 1'b0;
                    if (rresp != 2'b00) begin
                        abort = 1'b1;
                    end else begin
                        for (int j = 0; j < 8; j++) begin
                            if (rd_cnt == 3'(j)) nxt_dig_buf[255-32*j -: 32] = rdata;
                        end
                        if (rd_cnt == LAST_READ) begin
                            nxt_state = FINISH;
                        end else begin
                            nxt_rd_cnt  = rd_cnt + 3'd1;
                            nxt_araddr  = BASE_ADDR + DIGEST_OFS + (32'(rd_cnt + 3'd1) << 2);
                            nxt_arvalid = 1'b1;
                            nxt_state   = DIG_AR;
                        end
                    end
                end
            end
            FINISH: begin
                nxt_done      = 1'b1;
                nxt_digest    = dig_buf;
                nxt_cmd_ready = 1'b1;
                nxt_state     = IDLE;
            end
            default: nxt_state = IDLE;
        endcase

        if (abort) begin
            nxt_state     = IDLE;
            nxt_done      = 1'b1;
            nxt_error     = 1'b1;
            nxt_cmd_ready = 1'b1;
            nxt_awvalid   = 1'b0;
            nxt_wvalid    = 1'b0;
            nxt_bready    = 1'b0;
            nxt_arvalid   = 1'b0;
            nxt_rready    = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            digest    <= '0;
            awaddr    <= '0;
            wdata     <= '0;
            araddr    <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
`ifdef SHA256_AXIL_DRIVER_TIMEOUT_EN
            poll_cnt  <= '0;
`endif
        end else begin
            state     <= nxt_state;
            wr_cnt    <= nxt_wr_cnt;
            rd_cnt    <= nxt_rd_cnt;
            aw_done   <= nxt_aw_done;
            w_done    <= nxt_w_done;
            cmd_ready <= nxt_cmd_ready;
            done      <= nxt_done;
            error     <= nxt_error;
            digest    <= nxt_digest;
            awaddr    <= nxt_awaddr;
            wdata     <= nxt_wdata;
            araddr    <= nxt_araddr;
            awvalid   <= nxt_awvalid;
            wvalid    <= nxt_wvalid;
            bready    <= nxt_bready;
            arvalid   <= nxt_arvalid;
            rready    <= nxt_rready;
`ifdef SHA256_AXIL_DRIVER_TIMEOUT_EN
            poll_cnt  <= nxt_poll_cnt;
`endif
        end
    end

    // Captured block and shadow digest carry no reset; they are always loaded before use.
    always_ff @(posedge aclk) begin
        blk     <= nxt_blk;
        init    <= nxt_init;
        dig_buf <= nxt_dig_buf;
    end

endmodule

// File: tb/tb_sha256_axil_driver.sv
// Bench for sha256_axil_driver: behavioural AXI4-Lite SHA slave plus a list-based model of the expected bus traffic.
module tb_sha256_axil_driver;

    localparam logic [31:0] BASE = 32'h44B0_0000;

    logic         aclk, areset;
    logic         cmd_valid, cmd_ready, cmd_init;
    logic [511:0] cmd_block;
    logic         done, error;
    logic [255:0] digest;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic [2:0]   awprot, arprot;
    logic [3:0]   wstrb;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [1:0]   bresp, rresp;

    sha256_axil_driver #(.BASE_ADDR(BASE), .POLL_LIMIT(4)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_block(cmd_block), .cmd_init(cmd_init),
        .done(done), .error(error), .digest(digest),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          aw_dly, w_dly, ar_dly, polls_needed, n_status;
    bit          status_never;
    logic [31:0] wr_err_addr, rd_err_addr;
    logic [31:0] dig_words [8];
    logic [31:0] log_a[$], log_d[$];
    int          aw_cnt, w_cnt, ar_cnt;
    logic        a_got, w_got;
    logic [31:0] a_q, w_q;

    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid  && (w_cnt  >= w_dly);
    assign arready = arvalid && (ar_cnt >= ar_dly);

    always @(posedge aclk) begin : ready_delay
        aw_cnt <= (areset || !awvalid || awready) ? 0 : aw_cnt + 1;
        w_cnt  <= (areset || !wvalid  || wready)  ? 0 : w_cnt + 1;
        ar_cnt <= (areset || !arvalid || arready) ? 0 : ar_cnt + 1;
    end

    always @(posedge aclk) begin : slave
        logic [31:0] a, d;
        int off;
        if (areset) begin
            bvalid <= 1'b0; rvalid <= 1'b0; a_got <= 1'b0; w_got <= 1'b0;
            bresp <= 2'b00; rresp <= 2'b00; rdata <= 32'd0;
        end else begin
            if (bvalid && bready) bvalid <= 1'b0;
            if (rvalid && rready) rvalid <= 1'b0;
            if (awvalid && awready) begin a_got <= 1'b1; a_q <= awaddr; end
            if (wvalid && wready) begin w_got <= 1'b1; w_q <= wdata; end
            if ((a_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                a = (awvalid && awready) ? awaddr : a_q;
                d = (wvalid && wready) ? wdata : w_q;
                log_a.push_back(a);
                log_d.push_back(d);
                bvalid <= 1'b1;
                bresp  <= (a == wr_err_addr) ? 2'b10 : 2'b00;
                a_got  <= 1'b0;
                w_got  <= 1'b0;
            end
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rresp  <= (araddr == rd_err_addr) ? 2'b10 : 2'b00;
                if (araddr == BASE + 32'd8) begin
                    n_status = n_status + 1;
                    if (!status_never && n_status >= polls_needed) rdata <= $urandom | 32'h2;
                    else rdata <= $urandom & ~32'h2;
                end else if (araddr >= BASE + 32'd84 && araddr < BASE + 32'd116) begin
                    off = int'(araddr - BASE - 32'd84);
                    rdata <= dig_words[off / 4];
                end else begin
                    rdata <= 32'hDEAD_BEEF;
                end
            end
        end
    end

    // ---------------- protocol monitor ----------------
    logic        pv_awv, pv_awr, pv_wv, pv_wr, pv_arv, pv_arr, pv_rst;
    logic [31:0] pv_awaddr, pv_wdata, pv_araddr;

    always @(negedge aclk) begin : monitor
        if (pv_rst === 1'b0) begin
            if (pv_awv && !pv_awr) check("aw_hold", {awvalid, awaddr}, {1'b1, pv_awaddr});
            if (pv_wv && !pv_wr)   check("w_hold",  {wvalid, wdata},   {1'b1, pv_wdata});
            if (pv_arv && !pv_arr) check("ar_hold", {arvalid, araddr}, {1'b1, pv_araddr});
        end
        if (awvalid || arvalid) check("prot_strb", {awprot, arprot, wstrb}, {3'b0, 3'b0, 4'hF});
        if (arvalid) check("rw_overlap", {awvalid, wvalid, bready}, 3'b000);
        pv_awv = awvalid; pv_awr = awready; pv_awaddr = awaddr;
        pv_wv  = wvalid;  pv_wr  = wready;  pv_wdata  = wdata;
        pv_arv = arvalid; pv_arr = arready; pv_araddr = araddr;
        pv_rst = areset;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_waddr(input int k);
        return (k < 16) ? BASE + 32'd20 + 32'(4 * k) : BASE + 32'd4;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [511:0] b, input bit ini, input int k);
        if (k < 16) return 32'(b >> (480 - 32 * k));
        if (k == 16) return ini ? 32'h5 : 32'h6;
        return 32'h4;
    endfunction

    function automatic logic [255:0] exp_digest();
        logic [255:0] r = '0;
        for (int j = 0; j < 8; j++) r = (r << 32) | 256'(dig_words[j]);
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r = '0;
        for (int i = 0; i < 16; i++) r = (r << 32) | 512'($urandom);
        return r;
    endfunction

    task automatic load_digest(input logic [255:0] d);
        for (int j = 0; j < 8; j++) dig_words[j] = 32'(d >> (224 - 32 * j));
    endtask

    task automatic check_writes(input logic [511:0] b, input bit ini, input int n);
        check("wr_count", 256'(log_a.size()), 256'(n));
        for (int k = 0; k < n && k < log_a.size(); k++) begin
            check($sformatf("wr_addr%0d", k), log_a[k], exp_waddr(k));
            check($sformatf("wr_data%0d", k), log_d[k], exp_wdata(b, ini, k));
        end
    endtask

    // Issue one block and wait (bounded) for the done pulse.
    task automatic run_block(input logic [511:0] b, input bit ini, input bit busy_noise,
                             output int cyc, output bit got_err);
        bit got_done = 0;
        got_err = 0;
        log_a.delete(); log_d.delete(); n_status = 0;
        cmd_block = b; cmd_init = ini; cmd_valid = 1'b1;
        @(posedge aclk); #1;
        if (!busy_noise) cmd_valid = 1'b0;
        cyc = 0;
        while (cyc < 3000 && !got_done) begin
            if (busy_noise) begin cmd_block = rand512(); cmd_init = 1'($urandom); end
            @(posedge aclk); #1;
            cyc++;
            if (done) begin got_done = 1; got_err = error; end
        end
        cmd_valid = 1'b0;
        check("done_seen", got_done, 1'b1);
        @(posedge aclk); #1;
        check("done_pulse", {done, error}, 2'b00);
    endtask

    // ---------------- directed sequence ----------------
    logic [511:0] abc, b;
    logic [255:0] abc_dig, prev;
    int cyc, p;
    bit e, seen;

    initial begin
        areset = 1'b1; cmd_valid = 1'b0; cmd_block = '0; cmd_init = 1'b0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; polls_needed = 1; status_never = 0; n_status = 0;
        wr_err_addr = 32'd0; rd_err_addr = 32'd0;
        abc = {32'h61626380, 448'd0, 32'h00000018};
        abc_dig = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_done_err", {done, error}, 2'b00);
        check("rst_digest", digest, 256'd0);
        check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'd0);
        check("rst_addrs", {awaddr, wdata, araddr}, 96'd0);
        areset = 1'b0;
        @(posedge aclk); #1;
        check("rel_ready", cmd_ready, 1'b1);

        // "abc" with a zero-wait slave: minimum latency
        load_digest(abc_dig);
        run_block(abc, 1'b1, 1'b0, cyc, e);
        check("abc_latency", 256'(cyc), 256'd55);
        check("abc_err", e, 1'b0);
        check("abc_digest", digest, abc_dig);
        check("abc_polls", 256'(n_status), 256'd1);
        check_writes(abc, 1'b1, 18);

        // skewed AW/W acceptance in both directions
        aw_dly = 3;
        run_block(abc, 1'b1, 1'b0, cyc, e);
        check("awdly_err", e, 1'b0);
        check("awdly_digest", digest, abc_dig);
        check_writes(abc, 1'b1, 18);
        aw_dly = 0; w_dly = 3;
        run_block(abc, 1'b1, 1'b0, cyc, e);
        check("wdly_err", e, 1'b0);
        check("wdly_digest", digest, abc_dig);
        check_writes(abc, 1'b1, 18);
        w_dly = 0;

        // continuation block with cmd_valid toggling garbage while busy
        b = rand512();
        load_digest({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        run_block(b, 1'b0, 1'b1, cyc, e);
        check("cont_err", e, 1'b0);
        check("cont_digest", digest, exp_digest());
        check_writes(b, 1'b0, 18);
        repeat (10) @(posedge aclk);
        #1;
        check("busy_ignored", 256'(log_a.size()), 256'd18);
        check("idle_ready", cmd_ready, 1'b1);

        // SLVERR on BLOCK word 5
        prev = digest;
        wr_err_addr = BASE + 32'd40;
        b = rand512();
        run_block(b, 1'b1, 1'b0, cyc, e);
        check("berr_latency", 256'(cyc), 256'd12);
        check("berr_err", e, 1'b1);
        check("berr_digest", digest, prev);
        check_writes(b, 1'b1, 6);
        wr_err_addr = 32'd0;

        // SLVERR on DIGEST word 2
        rd_err_addr = BASE + 32'd92;
        load_digest({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        run_block(b, 1'b1, 1'b0, cyc, e);
        check("rerr_latency", 256'(cyc), 256'd44);
        check("rerr_err", e, 1'b1);
        check("rerr_digest", digest, prev);
        rd_err_addr = 32'd0;

        // reset pulse while reading DIGEST word 2
        cmd_block = rand512(); cmd_init = 1'b1; cmd_valid = 1'b1;
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (!(rready && araddr == BASE + 32'd92) && cyc < 2000) begin
            @(posedge aclk); #1; cyc++;
        end
        check("rst_reach_digr", {rready, araddr}, {1'b1, BASE + 32'd92});
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        check("midrst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'd0);
        check("midrst_digest", digest, 256'd0);
        seen = 0;
        repeat (80) begin
            @(posedge aclk); #1;
            if (done) seen = 1;
        end
        check("midrst_no_done", seen, 1'b0);
        check("midrst_ready", cmd_ready, 1'b1);

        // randomized blocks, delays and poll counts
        for (int t = 0; t < 6; t++) begin
            b = rand512();
            p = 1 + $urandom_range(0, 2);
            polls_needed = p;
            aw_dly = (t == 0) ? 0 : $urandom_range(0, 3);
            w_dly  = (t == 0) ? 0 : $urandom_range(0, 3);
            ar_dly = (t == 0) ? 0 : $urandom_range(0, 3);
            load_digest({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            run_block(b, t[0], 1'b0, cyc, e);
            check("rnd_err", e, 1'b0);
            check("rnd_digest", digest, exp_digest());
            check("rnd_polls", 256'(n_status), 256'(p));
            if (aw_dly == 0 && w_dly == 0 && ar_dly == 0)
                check("rnd_latency", 256'(cyc), 256'(53 + 2 * p));
            check_writes(b, t[0], 18);
        end
        aw_dly = 0; w_dly = 0; ar_dly = 0; polls_needed = 1;

`ifdef SHA256_AXIL_DRIVER_TIMEOUT_EN
        // STATUS never reports digest_valid
        prev = digest;
        status_never = 1;
        run_block(abc, 1'b1, 1'b0, cyc, e);
        check("tmo_err", e, 1'b1);
        check("tmo_polls", 256'(n_status), 256'd4);
        check("tmo_digest", digest, prev);
        status_never = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
